// File: rtl/dmem_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_bridge_if
// Brief    : data-memory req/ack bus between dmem_bridge and the memory system
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bridge_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output ack, rdata
   );
endinterface
`default_nettype wire

// File: rtl/dmem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : core load/store bridge: lane steering, load extension, LL/SC link,
//            stall generation and bus timeout on a req/ack data-memory bus
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic          mem_half,
   input  logic          mem_byte,
   input  logic          mem_sign_extend,
   input  logic          llsc,
   output logic [31:0]   rdata,
   output logic          stall,
   output logic          sc_result,
   output logic          addr_err,
   output logic          bus_err,
   dmem_bridge_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_link_valid;
   logic [29:0] r_link_addr;
   logic        r_load;
   logic        r_byte;
   logic        r_half;
   logic        r_sign;
   logic        r_sc;
   logic        r_ll;
   logic [1:0]  r_off;
   logic [31:0] r_rdata;
   logic        r_sc_result;
   logic        r_bus_err;

   logic        w_req;
   logic        w_misalign;
   logic        w_is_sc;
   logic        w_sc_fail;
   logic        w_idle;
   logic        w_go;
   logic        w_sc_drop;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_lane_b;
   logic [15:0] w_lane_h;
   logic [31:0] w_fmt;

   assign w_req      = mem_read | mem_write;
   assign w_misalign = mem_byte ? 1'b0 : (mem_half ? addr[0] : (|addr[1:0]));
   assign w_is_sc    = mem_write & llsc;
   assign w_sc_fail  = w_is_sc & (~r_link_valid | (addr[31:2] != r_link_addr));
   assign w_idle     = rst & (r_state == S_IDLE) & w_req;
   assign w_go       = w_idle & ~w_misalign & ~w_sc_fail;
   assign w_sc_drop  = w_idle & ~w_misalign & w_sc_fail;

   assign addr_err   = w_idle & w_misalign;
   assign stall      = w_go | (r_state == S_WAIT);
   assign rdata      = r_rdata;
   assign sc_result  = r_sc_result;
   assign bus_err    = r_bus_err;

   // Little-endian lane steering; narrow stores are replicated across the word
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata;
      if (mem_byte) begin
         w_be    = 4'b0001 << addr[1:0];
         w_wdata = {4{wdata[7:0]}};
      end else if (mem_half) begin
         w_be    = addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{wdata[15:0]}};
      end
   end

   always_comb begin
      w_lane_b = bus.rdata[{r_off, 3'b000} +: 8];
      w_lane_h = bus.rdata[{r_off[1], 4'b0000} +: 16];
      if (r_byte) begin
         w_fmt = {{24{r_sign & w_lane_b[7]}}, w_lane_b};
      end else if (r_half) begin
         w_fmt = {{16{r_sign & w_lane_h[15]}}, w_lane_h};
      end else begin
         w_fmt = bus.rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_link_valid <= 1'b0;
         r_link_addr  <= '0;
         r_load       <= 1'b0;
         r_byte       <= 1'b0;
         r_half       <= 1'b0;
         r_sign       <= 1'b0;
         r_sc         <= 1'b0;
         r_ll         <= 1'b0;
         r_off        <= '0;
         r_rdata      <= '0;
         r_sc_result  <= 1'b0;
         r_bus_err    <= 1'b0;
         bus.req      <= 1'b0;
         bus.we       <= 1'b0;
         bus.addr     <= '0;
         bus.wdata    <= '0;
         bus.be       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sc_drop) begin
                  r_link_valid <= 1'b0;
               end else if (w_go) begin
                  bus.req   <= 1'b1;
                  bus.we    <= mem_write;
                  bus.addr  <= {addr[31:2], 2'b00};
                  bus.wdata <= w_wdata;
                  bus.be    <= w_be;
                  r_load    <= ~mem_write;
                  r_byte    <= mem_byte;
                  r_half    <= ~mem_byte & mem_half;
                  r_sign    <= mem_sign_extend;
                  r_sc      <= w_is_sc;
                  r_ll      <= mem_read & ~mem_write & llsc;
                  r_off     <= addr[1:0];
                  r_cnt     <= '0;
                  r_state   <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (bus.ack) begin
                  bus.req     <= 1'b0;
                  r_rdata     <= r_load ? w_fmt : 32'd0;
                  r_sc_result <= r_sc;
                  r_state     <= S_DONE;
                  if (r_ll) begin
                     r_link_valid <= 1'b1;
                     r_link_addr  <= bus.addr[31:2];
                  end else if (r_sc) begin
                     r_link_valid <= 1'b0;
                  end else if (bus.we && (bus.addr[31:2] == r_link_addr)) begin
                     r_link_valid <= 1'b0;
                  end
               end else if (r_cnt == c_last) begin
                  // Abort: no data, and an SC that never reached memory still drops the link
                  bus.req   <= 1'b0;
                  r_rdata   <= '0;
                  r_bus_err <= 1'b1;
                  r_state   <= S_DONE;
                  if (r_sc) begin
                     r_link_valid <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_DONE: begin
               r_rdata     <= '0;
               r_sc_result <= 1'b0;
               r_bus_err   <= 1'b0;
               r_cnt       <= '0;
               r_state     <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Brief    : self-checking bench for dmem_bridge, directed scenarios plus
//            randomized accesses against an arithmetic reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_read;
   logic        mem_write;
   logic        mem_half;
   logic        mem_byte;
   logic        mem_sign_extend;
   logic        llsc;
   logic [31:0] rdata;
   logic        stall;
   logic        sc_result;
   logic        addr_err;
   logic        bus_err;

   int checks   = 0;
   int failures = 0;

   dmem_bridge_if bus_if ();

   dmem_bridge #(.TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .wdata           (wdata),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_half        (mem_half),
      .mem_byte        (mem_byte),
      .mem_sign_extend (mem_sign_extend),
      .llsc            (llsc),
      .rdata           (rdata),
      .stall           (stall),
      .sc_result       (sc_result),
      .addr_err        (addr_err),
      .bus_err         (bus_err),
      .bus             (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] stall_n;
      logic [15:0] req_n;
      logic        addr_err;
      logic [31:0] rdata;
      logic        sc;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] baddr;
      logic        we;
      logic        stable;
      logic        req_end;
      logic        clean;
   } obs_t;

   // Reference LL/SC link
   logic        m_link_valid;
   logic [29:0] m_link_addr;

   function automatic obs_t model(input logic rd, input logic wr, input logic hf, input logic by,
                                  input logic sx, input logic ll, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rdat, input int ack_at);
      obs_t        e;
      int          n;
      int          off;
      logic [31:0] v;
      logic [31:0] mask;
      logic        sc;
      logic        hit;
      logic        ok;
      e        = '0;
      e.stable = 1'b1;
      e.clean  = 1'b1;
      n        = by ? 1 : (hf ? 2 : 4);
      off      = int'(a % 4);
      if (!(rd || wr)) return e;
      if ((off % n) != 0) begin
         e.addr_err = 1'b1;
         return e;
      end
      sc  = wr && ll;
      hit = (a >> 2) == 32'(m_link_addr);
      if (sc && !(m_link_valid && hit)) begin
         m_link_valid = 1'b0;
         return e;
      end
      ok        = (ack_at >= 1) && (ack_at <= TIMEOUT);
      e.req_n   = 16'(ok ? ack_at : TIMEOUT);
      e.stall_n = e.req_n + 16'd1;
      e.err     = !ok;
      e.baddr   = a & ~32'h3;
      e.be      = 4'(((1 << n) - 1) << off);
      for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
      e.we = wr;
      if (rd && !wr && ok) begin
         mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
         v    = (rdat >> (8 * off)) & mask;
         if (sx && v[8*n-1]) v = v | ~mask;
         e.rdata = v;
      end
      e.sc = sc && ok;
      if (sc) m_link_valid = 1'b0;
      else if (rd && !wr && ll && ok) begin
         m_link_valid = 1'b1;
         m_link_addr  = a[31:2];
      end else if (wr && ok && hit) m_link_valid = 1'b0;
      return e;
   endfunction

   // Core side holds the request while stalled; memory acks on WAIT cycle ack_at (0 = never)
   task automatic run_access(input logic rd, input logic wr, input logic hf, input logic by,
                             input logic sx, input logic ll, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rdat, input int ack_at,
                             output obs_t o);
      int   guard;
      logic first;
      o        = '0;
      o.stable = 1'b1;
      first    = 1'b1;
      guard    = 0;
      mem_read = rd; mem_write = wr; mem_half = hf; mem_byte = by;
      mem_sign_extend = sx; llsc = ll; addr = a; wdata = wd;
      #1;
      o.addr_err = addr_err;
      while (stall === 1'b1 && guard < 300) begin
         o.stall_n = o.stall_n + 16'd1;
         if (bus_if.req === 1'b1) begin
            o.req_n = o.req_n + 16'd1;
            if (first) begin
               o.be = bus_if.be; o.wdata = bus_if.wdata; o.baddr = bus_if.addr; o.we = bus_if.we;
               first = 1'b0;
            end else if (bus_if.be !== o.be || bus_if.wdata !== o.wdata ||
                         bus_if.addr !== o.baddr || bus_if.we !== o.we) begin
               o.stable = 1'b0;
            end
            bus_if.ack   = (int'(o.req_n) == ack_at);
            bus_if.rdata = bus_if.ack ? rdat : $urandom;
         end
         @(posedge clk); #1;
         bus_if.ack = 1'b0;
         #1;
         guard++;
      end
      o.rdata   = rdata;
      o.sc      = sc_result;
      o.err     = bus_err;
      o.req_end = bus_if.req;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; llsc = 1'b0;
      #1;
      o.clean = (rdata === 32'd0) && (bus_err === 1'b0) && (sc_result === 1'b0) &&
                (bus_if.req === 1'b0) && (stall === 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      mem_read = 0; mem_write = 0; mem_half = 0; mem_byte = 0; mem_sign_extend = 0; llsc = 0;
      addr = '0; wdata = '0; bus_if.ack = 1'b0; bus_if.rdata = '0;
      m_link_valid = 1'b0; m_link_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus_if.req, bus_if.we, bus_if.be, stall, sc_result, addr_err, bus_err} !== 10'd0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0", {bus_if.req, bus_if.we, bus_if.be, stall, sc_result, addr_err, bus_err});
      end
      checks++;
      if ({bus_if.addr, bus_if.wdata, rdata} !== 96'd0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {bus_if.addr, bus_if.wdata, rdata});
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_byte_load;
      obs_t o, e;
      e = model(1, 0, 0, 1, 1, 0, 32'h103, 32'h0, 32'h80FF_FF12, 3);
      run_access(1, 0, 0, 1, 1, 0, 32'h103, 32'h0, 32'h80FF_FF12, 3, o);
      checks++;
      if (o.baddr !== 32'h100 || o.be !== 4'b1000 || o.we !== 1'b0) begin
         failures++;
         $display("FAIL lb_bus got addr=%h be=%b we=%b exp addr=00000100 be=1000 we=0", o.baddr, o.be, o.we);
      end
      checks++;
      if (o.stall_n !== 16'd4) begin
         failures++; $display("FAIL lb_stall got=%0d exp=4", o.stall_n);
      end
      checks++;
      if (o.rdata !== 32'hFFFF_FF80) begin
         failures++; $display("FAIL lb_signed got=%h exp=ffffff80", o.rdata);
      end
      e = model(1, 0, 0, 1, 0, 0, 32'h103, 32'h0, 32'h80FF_FF12, 3);
      run_access(1, 0, 0, 1, 0, 0, 32'h103, 32'h0, 32'h80FF_FF12, 3, o);
      checks++;
      if (o.rdata !== 32'h0000_0080 || o.clean !== 1'b1) begin
         failures++; $display("FAIL lb_unsigned got=%h clean=%b exp=00000080 clean=1", o.rdata, o.clean);
      end
   endtask

   task automatic test_half_store;
      obs_t o, e;
      e = model(0, 1, 1, 0, 0, 0, 32'h202, 32'h1234_ABCD, 32'h0, 1);
      run_access(0, 1, 1, 0, 0, 0, 32'h202, 32'h1234_ABCD, 32'h0, 1, o);
      checks++;
      if (o.wdata !== 32'hABCD_ABCD || o.be !== 4'b1100 || o.we !== 1'b1 || o.baddr !== 32'h200) begin
         failures++;
         $display("FAIL sh_bus got wdata=%h be=%b we=%b addr=%h exp abcdabcd 1100 1 00000200", o.wdata, o.be, o.we, o.baddr);
      end
      checks++;
      if (o.stall_n !== 16'd2 || o.rdata !== 32'd0) begin
         failures++; $display("FAIL sh_stall got stall=%0d rdata=%h exp stall=2 rdata=0", o.stall_n, o.rdata);
      end
   endtask

   task automatic test_misaligned;
      obs_t o, e;
      e = model(1, 0, 0, 0, 0, 0, 32'h301, 32'h0, 32'h0, 1);
      run_access(1, 0, 0, 0, 0, 0, 32'h301, 32'h0, 32'h0, 1, o);
      checks++;
      if (o.addr_err !== 1'b1 || o.stall_n !== 16'd0 || o.req_n !== 16'd0) begin
         failures++;
         $display("FAIL lw_misaligned got err=%b stall=%0d req=%0d exp err=1 stall=0 req=0", o.addr_err, o.stall_n, o.req_n);
      end
      e = model(1, 0, 1, 0, 0, 0, 32'h302, 32'h0, 32'hBEEF_0000, 1);
      run_access(1, 0, 1, 0, 0, 0, 32'h302, 32'h0, 32'hBEEF_0000, 1, o);
      checks++;
      if (o.addr_err !== 1'b0 || o.be !== 4'b1100 || o.rdata !== 32'h0000_BEEF) begin
         failures++;
         $display("FAIL lh_aligned got err=%b be=%b rdata=%h exp err=0 be=1100 rdata=0000beef", o.addr_err, o.be, o.rdata);
      end
   endtask

   task automatic test_llsc;
      obs_t o, e;
      e = model(1, 0, 0, 0, 0, 1, 32'h400, 32'h0, 32'h1111_2222, 2);
      run_access(1, 0, 0, 0, 0, 1, 32'h400, 32'h0, 32'h1111_2222, 2, o);
      e = model(0, 1, 0, 0, 0, 1, 32'h400, 32'h5A5A_5A5A, 32'h0, 1);
      run_access(0, 1, 0, 0, 0, 1, 32'h400, 32'h5A5A_5A5A, 32'h0, 1, o);
      checks++;
      if (o.sc !== 1'b1 || o.be !== 4'b1111 || o.we !== 1'b1 || o.req_n !== 16'd1) begin
         failures++;
         $display("FAIL sc_success got sc=%b be=%b we=%b req=%0d exp sc=1 be=1111 we=1 req=1", o.sc, o.be, o.we, o.req_n);
      end
      e = model(0, 1, 0, 0, 0, 1, 32'h400, 32'h0, 32'h0, 1);
      run_access(0, 1, 0, 0, 0, 1, 32'h400, 32'h0, 32'h0, 1, o);
      checks++;
      if (o.sc !== 1'b0 || o.req_n !== 16'd0 || o.stall_n !== 16'd0) begin
         failures++;
         $display("FAIL sc_repeat got sc=%b req=%0d stall=%0d exp sc=0 req=0 stall=0", o.sc, o.req_n, o.stall_n);
      end
      e = model(1, 0, 0, 0, 0, 1, 32'h400, 32'h0, 32'h0, 1);
      run_access(1, 0, 0, 0, 0, 1, 32'h400, 32'h0, 32'h0, 1, o);
      e = model(0, 1, 0, 0, 0, 0, 32'h400, 32'h7, 32'h0, 1);
      run_access(0, 1, 0, 0, 0, 0, 32'h400, 32'h7, 32'h0, 1, o);
      e = model(0, 1, 0, 0, 0, 1, 32'h400, 32'h9, 32'h0, 1);
      run_access(0, 1, 0, 0, 0, 1, 32'h400, 32'h9, 32'h0, 1, o);
      checks++;
      if (o.sc !== 1'b0 || o.req_n !== 16'd0) begin
         failures++; $display("FAIL sc_after_sw got sc=%b req=%0d exp sc=0 req=0", o.sc, o.req_n);
      end
   endtask

   task automatic test_timeout;
      obs_t o, e;
      e = model(1, 0, 0, 0, 0, 0, 32'h500, 32'h0, 32'h0, 0);
      run_access(1, 0, 0, 0, 0, 0, 32'h500, 32'h0, 32'h0, 0, o);
      checks++;
      if (o.req_n !== 16'd16 || o.stall_n !== 16'd17) begin
         failures++; $display("FAIL timeout_len got req=%0d stall=%0d exp req=16 stall=17", o.req_n, o.stall_n);
      end
      checks++;
      if (o.err !== 1'b1 || o.rdata !== 32'd0 || o.req_end !== 1'b0) begin
         failures++;
         $display("FAIL timeout_done got buserr=%b rdata=%h req=%b exp buserr=1 rdata=0 req=0", o.err, o.rdata, o.req_end);
      end
      @(posedge clk); #1;
      bus_if.ack = 1'b1; bus_if.rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      bus_if.ack = 1'b0;
      #1;
      checks++;
      if (bus_if.req !== 1'b0 || stall !== 1'b0 || rdata !== 32'd0 || bus_err !== 1'b0) begin
         failures++;
         $display("FAIL late_ack got req=%b stall=%b rdata=%h buserr=%b exp all 0", bus_if.req, stall, rdata, bus_err);
      end
      e = model(1, 0, 0, 0, 0, 0, 32'h504, 32'h0, 32'hCAFE_F00D, TIMEOUT);
      run_access(1, 0, 0, 0, 0, 0, 32'h504, 32'h0, 32'hCAFE_F00D, TIMEOUT, o);
      checks++;
      if (o.err !== 1'b0 || o.req_n !== 16'd16 || o.rdata !== 32'hCAFE_F00D) begin
         failures++;
         $display("FAIL ack_last_cycle got buserr=%b req=%0d rdata=%h exp buserr=0 req=16 rdata=cafef00d", o.err, o.req_n, o.rdata);
      end
   endtask

   task automatic test_reset_mid;
      obs_t o, e;
      e = model(1, 0, 0, 0, 0, 1, 32'h440, 32'h0, 32'h0, 1);
      run_access(1, 0, 0, 0, 0, 1, 32'h440, 32'h0, 32'h0, 1, o);
      mem_read = 1'b1; llsc = 1'b1; mem_half = 1'b0; mem_byte = 1'b0; addr = 32'h440;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus_if.req !== 1'b1 || stall !== 1'b1) begin
         failures++; $display("FAIL mid_wait got req=%b stall=%b exp req=1 stall=1", bus_if.req, stall);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      mem_read = 1'b0; llsc = 1'b0;
      #1;
      checks++;
      if (bus_if.req !== 1'b0 || stall !== 1'b0) begin
         failures++; $display("FAIL mid_reset got req=%b stall=%b exp req=0 stall=0", bus_if.req, stall);
      end
      rst = 1'b1;
      m_link_valid = 1'b0;
      @(posedge clk); #1;
      e = model(0, 1, 0, 0, 0, 1, 32'h440, 32'h3, 32'h0, 1);
      run_access(0, 1, 0, 0, 0, 1, 32'h440, 32'h3, 32'h0, 1, o);
      checks++;
      if (o.sc !== 1'b0 || o.req_n !== 16'd0) begin
         failures++; $display("FAIL sc_after_reset got sc=%b req=%0d exp sc=0 req=0", o.sc, o.req_n);
      end
   endtask

   task automatic test_random;
      obs_t        o, e;
      int          op;
      int          ack_at;
      logic        rd, wr, hf, by, sx, ll;
      logic [31:0] a, wd, rdat;
      for (int i = 0; i < 120; i++) begin
         op = int'($urandom_range(0, 8));
         rd = 0; wr = 0; hf = 0; by = 0; ll = 0;
         case (op)
            0: begin rd = 1; by = 1; end
            1: begin rd = 1; hf = 1; end
            2: rd = 1;
            3: begin wr = 1; by = 1; end
            4: begin wr = 1; hf = 1; end
            5: wr = 1;
            6: begin rd = 1; ll = 1; end
            7: begin wr = 1; ll = 1; end
            default: begin rd = 1; wr = 1; end
         endcase
         sx     = 1'($urandom_range(0, 1));
         a      = 32'h600 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
         wd     = $urandom;
         rdat   = $urandom;
         ack_at = int'($urandom_range(0, 9));
         ack_at = (ack_at == 0) ? 0 : ((ack_at % 5) + 1);
         e = model(rd, wr, hf, by, sx, ll, a, wd, rdat, ack_at);
         run_access(rd, wr, hf, by, sx, ll, a, wd, rdat, ack_at, o);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL random[%0d] op=%0d addr=%h ack=%0d got=%h exp=%h", i, op, a, ack_at, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte_load();
      test_half_store();
      test_misaligned();
      test_llsc();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
